// File: rtl/axi_lite_master_bridge.sv
// axi_lite_master_bridge
//   Turns a single-outstanding req/gnt/rvalid memory port into AXI-Lite
//   master transactions. One read or one write is in flight at a time; the
//   response comes back to the requester as a one-cycle rvalid_o pulse with
//   an error flag taken from bit 1 of the AXI response.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   req_i/we_i/addr_i/wdata_i/be_i   request side (held until gnt_o)
//   gnt_o               request accepted (IDLE only)
//   rvalid_o/rdata_o/err_o           response pulse, read data, error
//   aw_* / w_* / b_*    AXI-Lite write address, data, response channels
//   ar_* / r_*          AXI-Lite read address, read data channels
//
// State | meaning
//   S_IDLE    | waiting for req_i; grants combinationally and captures
//   S_WR_REQ  | aw/w valids out, each drops after its own handshake
//   S_WR_RESP | b_ready high, waiting for the write response
//   S_RD_REQ  | ar_valid out, waiting for ar_ready
//   S_RD_RESP | r_ready high, waiting for read data
module axi_lite_master_bridge #(
   parameter int unsigned       MEM_AW    = 16,
   parameter int unsigned       DW        = 32,
   parameter int unsigned       AXI_AW    = 32,
   parameter logic [AXI_AW-1:0] ADDR_BASE = '0
) (
   input  logic              clk_i,
   input  logic              rst_i,

   input  logic              req_i,
   input  logic              we_i,
   input  logic [MEM_AW-1:0] addr_i,
   input  logic [DW-1:0]     wdata_i,
   input  logic [DW/8-1:0]   be_i,
   output logic              gnt_o,
   output logic              rvalid_o,
   output logic [DW-1:0]     rdata_o,
   output logic              err_o,

   output logic [AXI_AW-1:0] aw_addr_o,
   output logic [2:0]        aw_prot_o,
   output logic              aw_valid_o,
   input  logic              aw_ready_i,
   output logic [DW-1:0]     w_data_o,
   output logic [DW/8-1:0]   w_strb_o,
   output logic              w_valid_o,
   input  logic              w_ready_i,
   input  logic [1:0]        b_resp_i,
   input  logic              b_valid_i,
   output logic              b_ready_o,

   output logic [AXI_AW-1:0] ar_addr_o,
   output logic [2:0]        ar_prot_o,
   output logic              ar_valid_o,
   input  logic              ar_ready_i,
   input  logic [DW-1:0]     r_data_i,
   input  logic [1:0]        r_resp_i,
   input  logic              r_valid_i,
   output logic              r_ready_o
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WR_REQ  = 3'd1;
   localparam logic [2:0] S_WR_RESP = 3'd2;
   localparam logic [2:0] S_RD_REQ  = 3'd3;
   localparam logic [2:0] S_RD_RESP = 3'd4;

   logic [2:0]        r_state;
   logic [AXI_AW-1:0] r_axi_addr;
   logic [DW-1:0]     r_wdata;
   logic [DW/8-1:0]   r_strb;
   logic              r_aw_valid;
   logic              r_w_valid;
   logic              r_ar_valid;
   logic              r_rvalid;
   logic [DW-1:0]     r_rdata;
   logic              r_err;

   logic [AXI_AW-1:0] w_axi_addr;
   logic              w_aw_pend;
   logic              w_w_pend;
   logic              w_unused;

   // Only bit 1 of the AXI response (SLVERR/DECERR) matters to the requester.
   assign w_unused   = b_resp_i[0] ^ r_resp_i[0];

   assign w_axi_addr = ADDR_BASE | AXI_AW'(addr_i);

   // A channel is still pending while its valid is up and ready is not.
   assign w_aw_pend  = r_aw_valid && !aw_ready_i;
   assign w_w_pend   = r_w_valid  && !w_ready_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= S_IDLE;
         r_axi_addr <= '0;
         r_wdata    <= '0;
         r_strb     <= '0;
         r_aw_valid <= 1'b0;
         r_w_valid  <= 1'b0;
         r_ar_valid <= 1'b0;
         r_rvalid   <= 1'b0;
         r_rdata    <= '0;
         r_err      <= 1'b0;
      end else begin
         r_rvalid <= 1'b0;
         r_err    <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (req_i) begin
                  r_axi_addr <= w_axi_addr;
                  if (we_i) begin
                     r_wdata    <= wdata_i;
                     r_strb     <= be_i;
                     r_aw_valid <= 1'b1;
                     r_w_valid  <= 1'b1;
                     r_state    <= S_WR_REQ;
                  end else begin
                     r_ar_valid <= 1'b1;
                     r_state    <= S_RD_REQ;
                  end
               end
            end
            S_WR_REQ: begin
               if (r_aw_valid && aw_ready_i) r_aw_valid <= 1'b0;
               if (r_w_valid && w_ready_i)   r_w_valid  <= 1'b0;
               // Covers both channels finishing together or in either order.
               if (!w_aw_pend && !w_w_pend) begin
                  r_wdata <= '0;
                  r_strb  <= '0;
                  r_state <= S_WR_RESP;
               end
            end
            S_WR_RESP: begin
               if (b_valid_i) begin
                  r_rvalid <= 1'b1;
                  r_err    <= b_resp_i[1];
                  r_state  <= S_IDLE;
               end
            end
            S_RD_REQ: begin
               if (ar_ready_i) begin
                  r_ar_valid <= 1'b0;
                  r_state    <= S_RD_RESP;
               end
            end
            S_RD_RESP: begin
               if (r_valid_i) begin
                  r_rvalid <= 1'b1;
                  r_rdata  <= r_data_i;
                  r_err    <= r_resp_i[1];
                  r_state  <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Grant is a pure decode of state and req_i, so a new request can be
   // accepted in the same cycle the previous response pulses.
   assign gnt_o      = (r_state == S_IDLE) && req_i;
   assign rvalid_o   = r_rvalid;
   assign rdata_o    = r_rdata;
   assign err_o      = r_err;

   assign aw_addr_o  = r_axi_addr;
   assign aw_prot_o  = 3'b000;
   assign aw_valid_o = r_aw_valid;
   assign w_data_o   = r_wdata;
   assign w_strb_o   = r_strb;
   assign w_valid_o  = r_w_valid;
   assign b_ready_o  = (r_state == S_WR_RESP);

   assign ar_addr_o  = r_axi_addr;
   assign ar_prot_o  = 3'b000;
   assign ar_valid_o = r_ar_valid;
   assign r_ready_o  = (r_state == S_RD_RESP);

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
module tb_axi_lite_master_bridge;

   localparam int unsigned MEM_AW = 16;
   localparam int unsigned DW     = 32;
   localparam int unsigned AXI_AW = 32;
   localparam logic [31:0] BASE   = 32'h4000_0000;

   logic              clk_i = 1'b0;
   logic              rst_i = 1'b1;
   logic              req_i = 1'b0;
   logic              we_i = 1'b0;
   logic [MEM_AW-1:0] addr_i = '0;
   logic [DW-1:0]     wdata_i = '0;
   logic [DW/8-1:0]   be_i = '0;
   logic              gnt_o, rvalid_o, err_o;
   logic [DW-1:0]     rdata_o;
   logic [AXI_AW-1:0] aw_addr_o, ar_addr_o;
   logic [2:0]        aw_prot_o, ar_prot_o;
   logic              aw_valid_o, w_valid_o, b_ready_o, ar_valid_o, r_ready_o;
   logic              aw_ready_i = 1'b0, w_ready_i = 1'b0, ar_ready_i = 1'b0;
   logic              b_valid_i = 1'b0, r_valid_i = 1'b0;
   logic [1:0]        b_resp_i = '0, r_resp_i = '0;
   logic [DW-1:0]     w_data_o;
   logic [DW/8-1:0]   w_strb_o;
   logic [DW-1:0]     r_data_i = '0;

   axi_lite_master_bridge #(
      .MEM_AW(MEM_AW), .DW(DW), .AXI_AW(AXI_AW), .ADDR_BASE(BASE)
   ) u_dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i), .be_i(be_i),
      .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
      .aw_addr_o(aw_addr_o), .aw_prot_o(aw_prot_o), .aw_valid_o(aw_valid_o),
      .aw_ready_i(aw_ready_i),
      .w_data_o(w_data_o), .w_strb_o(w_strb_o), .w_valid_o(w_valid_o),
      .w_ready_i(w_ready_i),
      .b_resp_i(b_resp_i), .b_valid_i(b_valid_i), .b_ready_o(b_ready_o),
      .ar_addr_o(ar_addr_o), .ar_prot_o(ar_prot_o), .ar_valid_o(ar_valid_o),
      .ar_ready_i(ar_ready_i),
      .r_data_i(r_data_i), .r_resp_i(r_resp_i), .r_valid_i(r_valid_i),
      .r_ready_o(r_ready_o)
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } resp_t;
   resp_t sb_q[$];

   // parameters of the transaction currently owned by the AXI slave model
   logic [31:0] act_addr = '0, act_wdata = '0, act_rdata = '0;
   logic [3:0]  act_be = '0;
   logic [1:0]  act_resp = '0;
   int act_la = 0, act_lw = 0, act_lr = 0, act_lresp = 0;

   logic [31:0] last_rdata = '0;
   int n_exp_wr = 0, n_exp_rd = 0;
   int n_aw_hs = 0, n_w_hs = 0, n_ar_hs = 0;
   int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;

   // AXI-Lite slave model: each ready/valid rises after a programmed number
   // of cycles counted from the start of the corresponding DUT valid/ready.
   always @(negedge clk_i) begin
      if (rst_i) begin
         aw_ready_i = 0; w_ready_i = 0; ar_ready_i = 0; b_valid_i = 0; r_valid_i = 0;
         aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
      end else begin
         if (aw_valid_o) begin
            chk("aw_addr", aw_addr_o, act_addr);
            chk("aw_prot", aw_prot_o, 0);
            aw_cnt++;
            aw_ready_i = (aw_cnt > act_la);
            if (aw_ready_i) n_aw_hs++;
         end else begin
            aw_cnt = 0; aw_ready_i = 0;
         end
         if (w_valid_o) begin
            chk("w_data", w_data_o, act_wdata);
            chk("w_strb", w_strb_o, act_be);
            w_cnt++;
            w_ready_i = (w_cnt > act_lw);
            if (w_ready_i) n_w_hs++;
         end else begin
            w_cnt = 0; w_ready_i = 0;
         end
         if (ar_valid_o) begin
            chk("ar_addr", ar_addr_o, act_addr);
            chk("ar_prot", ar_prot_o, 0);
            ar_cnt++;
            ar_ready_i = (ar_cnt > act_lr);
            if (ar_ready_i) n_ar_hs++;
         end else begin
            ar_cnt = 0; ar_ready_i = 0;
         end
         if (b_ready_o) begin
            b_cnt++;
            b_valid_i = (b_cnt > act_lresp);
         end else begin
            b_cnt = 0; b_valid_i = 0;
         end
         b_resp_i = act_resp;
         if (r_ready_o) begin
            r_cnt++;
            r_valid_i = (r_cnt > act_lresp);
         end else begin
            r_cnt = 0; r_valid_i = 0;
         end
         r_resp_i = act_resp;
         r_data_i = r_valid_i ? act_rdata : 32'hBAD0_BAD0;
         if (b_ready_o || ar_valid_o || r_ready_o) begin
            chk("w_data_zero", w_data_o, 0);
            chk("w_strb_zero", w_strb_o, 0);
         end
      end
   end

   // response monitor: pops the scoreboard on every rvalid_o pulse
   resp_t mon_e;
   always @(negedge clk_i) begin
      if (!rst_i) begin
         if (rvalid_o) begin
            if (sb_q.size() == 0) begin
               chk("spurious_rvalid", 1, 0);
            end else begin
               mon_e = sb_q.pop_front();
               chk("rdata", rdata_o, mon_e.rdata);
               chk("err", err_o, mon_e.err);
               chk("rvalid_cycle", cyc, mon_e.cyc);
            end
         end else begin
            chk("err_idle", err_o, 0);
         end
      end
   end

   // Called at a negedge. Holds req_i until granted; leaves req_i high on
   // return so the next call continues a back-to-back stream.
   task automatic issue(input logic we, input logic [15:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [31:0] rdata, input logic [1:0] resp,
                        input int la, input int lw, input int lr, input int lresp,
                        input bit exp_resp, input bit exp_b2b);
      bit granted = 0;
      resp_t e;
      req_i = 1; we_i = we; addr_i = addr; wdata_i = wdata; be_i = be;
      for (int i = 0; i < 300; i++) begin
         #1;
         if (gnt_o) begin
            granted = 1;
            break;
         end
         @(negedge clk_i);
      end
      if (!granted) begin
         chk("gnt_timeout", 0, 1);
         req_i = 0;
         return;
      end
      if (exp_b2b) chk("b2b_gnt_with_rvalid", rvalid_o, 1);
      act_addr = BASE | {16'h0, addr}; act_wdata = wdata; act_be = be;
      act_rdata = rdata; act_resp = resp;
      act_la = la; act_lw = lw; act_lr = lr; act_lresp = lresp;
      if (exp_resp) begin
         if (we) begin
            e.rdata = last_rdata;
            e.cyc   = cyc + 3 + ((la > lw) ? la : lw) + lresp;
            n_exp_wr++;
         end else begin
            e.rdata    = rdata;
            e.cyc      = cyc + 3 + lr + lresp;
            last_rdata = rdata;
            n_exp_rd++;
         end
         e.err = resp[1];
         sb_q.push_back(e);
      end
      @(negedge clk_i);
   endtask

   task automatic drain();
      req_i = 0;
      for (int i = 0; i < 300 && sb_q.size() != 0; i++) @(negedge clk_i);
      chk("drain", sb_q.size(), 0);
      repeat (2) @(negedge clk_i);
   endtask

   task automatic chk_reset_outputs(input string p);
      chk({p, "_gnt"}, gnt_o, 0);
      chk({p, "_rvalid"}, rvalid_o, 0);
      chk({p, "_rdata"}, rdata_o, 0);
      chk({p, "_err"}, err_o, 0);
      chk({p, "_aw_valid"}, aw_valid_o, 0);
      chk({p, "_w_valid"}, w_valid_o, 0);
      chk({p, "_ar_valid"}, ar_valid_o, 0);
      chk({p, "_b_ready"}, b_ready_o, 0);
      chk({p, "_r_ready"}, r_ready_o, 0);
      chk({p, "_aw_addr"}, aw_addr_o, 0);
      chk({p, "_ar_addr"}, ar_addr_o, 0);
      chk({p, "_w_data"}, w_data_o, 0);
      chk({p, "_w_strb"}, w_strb_o, 0);
      chk({p, "_prot"}, {aw_prot_o, ar_prot_o}, 0);
   endtask

   initial begin
      rst_i = 1;
      repeat (3) @(negedge clk_i);
      chk_reset_outputs("por");
      rst_i = 0;
      @(negedge clk_i);

      // zero-wait write, then split write handshakes (w_ready 3 cycles late)
      issue(1, 16'h0010, 32'hDEAD_BEEF, 4'hF, 0, 2'b00, 0, 0, 0, 0, 1, 0);
      drain();
      issue(1, 16'h0014, 32'hA5A5_5A5A, 4'b0101, 0, 2'b00, 0, 3, 0, 0, 1, 0);
      drain();

      // read with slave stall, then a write must leave rdata_o alone
      issue(0, 16'h0100, 0, 0, 32'h1234_5678, 2'b00, 0, 0, 2, 2, 1, 0);
      drain();
      issue(1, 16'h0104, 32'h0000_1111, 4'h1, 0, 2'b00, 1, 0, 0, 1, 1, 0);
      drain();

      // error responses followed by an OKAY
      issue(1, 16'h0108, 32'h7777_0000, 4'hC, 0, 2'b10, 0, 0, 0, 0, 1, 0);
      drain();
      issue(0, 16'h010C, 0, 0, 32'h0BAD_F00D, 2'b11, 0, 0, 0, 0, 1, 0);
      drain();
      issue(0, 16'h0110, 0, 0, 32'h55AA_55AA, 2'b00, 0, 0, 0, 0, 1, 0);
      drain();

      // back-to-back alternating read/write with req_i held high
      for (int i = 0; i < 6; i++) begin
         issue(i[0], 16'h0200 + 16'(i * 4), 32'hC000_0000 + 32'(i), 4'hF,
               32'h9000_0000 + 32'(i), 2'b00, 0, 0, 0, 0, 1, (i > 0));
      end
      drain();

      // reset while aw_valid is up and w is pending
      issue(1, 16'h0300, 32'hCAFE_F00D, 4'h3, 0, 2'b00, 3, 5, 0, 0, 0, 0);
      req_i = 0;
      rst_i = 1;
      @(negedge clk_i);
      rst_i = 0;
      chk_reset_outputs("rst_mid");
      last_rdata = 0;
      repeat (3) @(negedge clk_i);
      issue(0, 16'h0304, 0, 0, 32'h0F0F_0F0F, 2'b00, 0, 0, 1, 0, 1, 0);
      drain();

      // randomized latencies and responses
      for (int i = 0; i < 12; i++) begin
         issue(1'($urandom_range(0, 1)), 16'($urandom), $urandom, 4'($urandom),
               $urandom, 2'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 3), 1, 0);
         if ($urandom_range(0, 1) == 1) drain();
      end
      drain();

      chk("sb_empty", sb_q.size(), 0);
      chk("aw_hs_count", n_aw_hs, n_exp_wr);
      chk("w_hs_count", n_w_hs, n_exp_wr);
      chk("ar_hs_count", n_ar_hs, n_exp_rd);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got=%0d exp=finish", cyc);
      $fatal(1, "timeout");
   end

endmodule
